spu_dmem: RTL and testbench

- Data-memory responder on the SPU's dm_* interface: the SPU is the initiator, this block answers its reads and writes.
- Holds a 256x16 word array with a registered read (one-cycle latency).
- Adds a host port so the test harness / system controller can preload and read back data while the SPU is stopped.
- Contains a clear engine that zero-fills the whole array on request.

---
 rtl/spu_dmem_pkg.sv | 21 ++
 rtl/spu_dmem_ram.sv | 41 ++++
 rtl/spu_dmem.sv | 172 +++++++++++++++++
 tb/tb_spu_dmem.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spu_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spu_dmem_pkg
// Purpose  : Shared constants and state encoding for the SPU data memory.
// Contents : SPU_AW / SPU_DW / SPU_DEPTH sizing constants,
//            dmem_state_t (IDLE, CLEAR).
// Revision : 1.0 - initial release
// ============================================================================
package spu_dmem_pkg;

  localparam int SPU_AW    = 8;
  localparam int SPU_DW    = 16;
  localparam int SPU_DEPTH = 1 << SPU_AW;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/spu_dmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : spu_dmem_ram
// Purpose  : Single-port synchronous RAM with a registered read port.
//            A read and a write to the same address in one cycle return
//            the old word (read-before-write).
// Ports    : clk   - clock
//            we    - write enable
//            re    - read enable; rdata only updates when set
//            addr  - word address
//            wdata - write data
//            rdata - registered read data
// Revision : 1.0 - initial release
// ============================================================================
module spu_dmem_ram #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Both statements sample mem before the edge, giving read-before-write.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[addr];
    end
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : spu_dmem
// Purpose  : SPU data memory responder. 256x16 array shared between the SPU
//            port (active while the SPU runs), a host port (active while the
//            SPU is stopped) and a zero-fill clear engine.
// Ports    : clk, rst                          - clock, sync active-high reset
//            dm_addr/dm_rd/dm_wr/dm_w_data     - SPU request
//            dm_r_data                         - SPU read data (1-cycle latency)
//            spu_stop                          - 1 = host owns the memory
//            host_addr/host_rd/host_wr/host_w_data - host request
//            host_r_data/host_ack/host_err     - host response (1-cycle)
//            clr_req / clr_busy                - zero-fill request / status
// Revision : 1.0 - initial release
// ============================================================================
module spu_dmem
  import spu_dmem_pkg::*;
#(
  parameter int AW    = SPU_AW,
  parameter int DW    = SPU_DW,
  parameter int DEPTH = SPU_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] dm_addr,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [DW-1:0] dm_w_data,
  output logic [DW-1:0] dm_r_data,
  input  logic          spu_stop,
  input  logic [AW-1:0] host_addr,
  input  logic          host_rd,
  input  logic          host_wr,
  input  logic [DW-1:0] host_w_data,
  output logic [DW-1:0] host_r_data,
  output logic          host_ack,
  output logic          host_err,
  input  logic          clr_req,
  output logic          clr_busy
);

  dmem_state_t   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          is_idle;
  logic          host_req;
  logic          host_ok;
  logic          spu_ok;

  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // Which port issued the RAM read last cycle; the other port keeps its
  // previously returned word in its hold register.
  logic          spu_rd_q;
  logic          host_rd_q;
  logic [DW-1:0] dm_hold_q;
  logic [DW-1:0] host_hold_q;

  assign is_idle  = (state_q == IDLE);
  assign host_req = host_rd | host_wr;
  assign host_ok  = host_req & spu_stop & is_idle;
  assign spu_ok   = ~spu_stop & is_idle;
  assign clr_busy = (state_q == CLEAR);

  // --------------------------------------------------------------------------
  // Clear engine state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req && spu_stop) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        // Counter wraps back to 0 naturally after the last address.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // RAM port arbitration: clear > host > SPU
  // --------------------------------------------------------------------------
  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!is_idle) begin
      ram_we    = 1'b1;
      ram_addr  = cnt_q;
      ram_wdata = '0;
    end else if (spu_stop) begin
      ram_we    = host_wr;
      ram_re    = host_rd;
      ram_addr  = host_addr;
      ram_wdata = host_w_data;
    end else begin
      ram_we    = dm_wr;
      ram_re    = dm_rd;
      ram_addr  = dm_addr;
      ram_wdata = dm_w_data;
    end
    // A reset arriving mid-clear must not complete that cycle's write.
    if (rst) begin
      ram_we = 1'b0;
    end
  end

  spu_dmem_ram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // --------------------------------------------------------------------------
  // Response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      spu_rd_q    <= 1'b0;
      host_rd_q   <= 1'b0;
      dm_hold_q   <= '0;
      host_hold_q <= '0;
      host_ack    <= 1'b0;
      host_err    <= 1'b0;
    end else begin
      spu_rd_q    <= spu_ok & dm_rd;
      host_rd_q   <= host_ok & host_rd;
      dm_hold_q   <= dm_r_data;
      host_hold_q <= host_r_data;
      host_ack    <= host_ok;
      host_err    <= host_req & ~(spu_stop & is_idle);
    end
  end

  assign dm_r_data   = spu_rd_q  ? ram_rdata : dm_hold_q;
  assign host_r_data = host_rd_q ? ram_rdata : host_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_spu_dmem.sv
`default_nettype none
// ============================================================================
// Module   : tb_spu_dmem
// Purpose  : Self-checking bench for spu_dmem: directed vector table for
//            single-cycle SPU/host accesses, plus hand-written sequences for
//            clear length, reset mid-clear and ignored clear requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spu_dmem;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic [AW-1:0] dm_addr;
  logic          dm_rd;
  logic          dm_wr;
  logic [DW-1:0] dm_w_data;
  logic [DW-1:0] dm_r_data;
  logic          spu_stop;
  logic [AW-1:0] host_addr;
  logic          host_rd;
  logic          host_wr;
  logic [DW-1:0] host_w_data;
  logic [DW-1:0] host_r_data;
  logic          host_ack;
  logic          host_err;
  logic          clr_req;
  logic          clr_busy;

  int total;
  int bad;

  spu_dmem dut (
    .clk         (clk),
    .rst         (rst),
    .dm_addr     (dm_addr),
    .dm_rd       (dm_rd),
    .dm_wr       (dm_wr),
    .dm_w_data   (dm_w_data),
    .dm_r_data   (dm_r_data),
    .spu_stop    (spu_stop),
    .host_addr   (host_addr),
    .host_rd     (host_rd),
    .host_wr     (host_wr),
    .host_w_data (host_w_data),
    .host_r_data (host_r_data),
    .host_ack    (host_ack),
    .host_err    (host_err),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          stop;
    logic          host;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_ack;
    logic          exp_err;
    logic          chk_dm;
    logic [DW-1:0] exp_dm;
    logic          chk_host;
    logic [DW-1:0] exp_host;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dm_rd   = 1'b0;
    dm_wr   = 1'b0;
    host_rd = 1'b0;
    host_wr = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    host_addr = a;
    host_rd   = 1'b1;
    tick();
    host_rd   = 1'b0;
    check({name, "_ack"}, {15'd0, host_ack}, 16'd1);
    check(name, host_r_data, exp);
  endtask

  initial begin
    int cycles;
    int guard;
    int k;
    total = 0;
    bad   = 0;

    //                stop host rd   wr   addr   wdata     ack  err  chkdm dm        chkh host
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 16'hAAAA, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 16'h5555, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hAAAA};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000};

    rst         = 1'b1;
    spu_stop    = 1'b1;
    dm_addr     = '0;
    dm_w_data   = '0;
    host_addr   = '0;
    host_w_data = '0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;

    check("rst_dm_r_data",   dm_r_data,            16'h0000);
    check("rst_host_r_data", host_r_data,          16'h0000);
    check("rst_host_ack",    {15'd0, host_ack},    16'd0);
    check("rst_host_err",    {15'd0, host_err},    16'd0);
    check("rst_clr_busy",    {15'd0, clr_busy},    16'd0);

    // ---------------- table-driven single-cycle accesses ----------------
    for (int i = 0; i < NVEC; i++) begin
      spu_stop    = vecs[i].stop;
      dm_addr     = vecs[i].addr;
      host_addr   = vecs[i].addr;
      dm_w_data   = vecs[i].wdata;
      host_w_data = vecs[i].wdata;
      dm_rd       = vecs[i].host ? 1'b0 : vecs[i].rd;
      dm_wr       = vecs[i].host ? 1'b0 : vecs[i].wr;
      host_rd     = vecs[i].host ? vecs[i].rd : 1'b0;
      host_wr     = vecs[i].host ? vecs[i].wr : 1'b0;
      tick();
      idle_inputs();
      check($sformatf("vec%0d_ack", i), {15'd0, host_ack}, {15'd0, vecs[i].exp_ack});
      check($sformatf("vec%0d_err", i), {15'd0, host_err}, {15'd0, vecs[i].exp_err});
      if (vecs[i].chk_dm)
        check($sformatf("vec%0d_dm", i), dm_r_data, vecs[i].exp_dm);
      if (vecs[i].chk_host)
        check($sformatf("vec%0d_host", i), host_r_data, vecs[i].exp_host);
    end

    // ---------------- clear with simultaneous host read ----------------
    spu_stop  = 1'b1;
    clr_req   = 1'b1;
    host_addr = 8'h10;
    host_rd   = 1'b1;
    tick();
    idle_inputs();
    check("clr_host_ack",  {15'd0, host_ack}, 16'd1);
    check("clr_host_data", host_r_data,       16'hBEEF);
    check("clr_busy_rise", {15'd0, clr_busy}, 16'd1);
    cycles = clr_busy ? 1 : 0;
    guard  = 0;
    while (clr_busy && guard < 400) begin
      host_rd = (guard == 5);
      tick();
      host_rd = 1'b0;
      if (guard == 5) begin
        check("clr_host_err", {15'd0, host_err}, 16'd1);
        check("clr_host_noack", {15'd0, host_ack}, 16'd0);
        check("clr_host_hold", host_r_data, 16'hBEEF);
      end
      if (clr_busy) cycles++;
      guard++;
    end
    check("clr_busy_cycles", 16'(cycles), 16'd256);
    host_read(8'h10, 16'h0000, "post_clr_10");
    host_read(8'hFF, 16'h0000, "post_clr_ff");
    host_read(8'h05, 16'h0000, "post_clr_05");

    // ---------------- reset 100 cycles into a clear ----------------
    host_w_data = 16'hFFFF;
    for (int a = 0; a < 256; a++) begin
      host_addr = 8'(a);
      host_wr   = 1'b1;
      tick();
    end
    host_wr = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (k = 1; k < 100; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_clr_busy", {15'd0, clr_busy}, 16'd0);
    for (int a = 0; a < 256; a++) begin
      host_read(8'(a), (a < 8'h63) ? 16'h0000 : 16'hFFFF, $sformatf("partial_%02h", a));
    end

    // ---------------- clear request ignored while SPU runs ----------------
    spu_stop = 1'b0;
    clr_req  = 1'b1;
    tick();
    clr_req = 1'b0;
    check("ign_clr_busy0", {15'd0, clr_busy}, 16'd0);
    tick();
    check("ign_clr_busy1", {15'd0, clr_busy}, 16'd0);
    spu_stop = 1'b1;
    host_read(8'h63, 16'hFFFF, "ign_clr_63");
    host_read(8'hFF, 16'hFFFF, "ign_clr_ff");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
